// File: rtl/lcm_cfg_pkg.sv
// Shared types and field positions for the LCD-controller register arbiter.
// The register word layout is {addr[5:0], 2'b00, value[7:0]}.
package lcm_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        GAP,
        DONE
    } lcm_state_e;

    typedef logic [15:0] lcm_word_t;

    localparam int ADDR_MSB = 15;
    localparam int ADDR_LSB = 10;
    localparam int VAL_MSB  = 7;
    localparam int VAL_LSB  = 0;

    function automatic logic [5:0] word_addr(input lcm_word_t w);
        return w[ADDR_MSB:ADDR_LSB];
    endfunction

    function automatic logic [7:0] word_val(input lcm_word_t w);
        return w[VAL_MSB:VAL_LSB];
    endfunction

endpackage

// File: rtl/lcm_reg_arbiter_rr_pick.sv
// Two-requester round-robin selector; i_ptr names the requester that
// wins when both ask at once.
module lcm_rr_pick (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic       o_any,
    output logic       o_gnt
);

    assign o_any = |i_req;
    assign o_gnt = (&i_req) ? i_ptr : i_req[1];

endmodule

// File: rtl/lcm_reg_arbiter.sv
// Two-port register-write arbiter in front of a serial LCD controller.
// Define LCM_ARB_RETRY_EN to build in NACK re-issue (up to MAX_RETRY).
module lcm_reg_arbiter
    import lcm_cfg_pkg::*;
#(
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 4095
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iREQ_0,
    input  logic        iREQ_1,
    input  logic [15:0] iDATA_0,
    input  logic [15:0] iDATA_1,
    output logic        oDONE_0,
    output logic        oDONE_1,
    output logic        oERR_0,
    output logic        oERR_1,
    output logic        oBUSY,
    output logic [15:0] oDATA,
    output logic        oSTR,
    input  logic        iRDY,
    input  logic        iACK
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    lcm_state_e    r_state;
    logic [TW-1:0] r_tcnt;
    logic          r_ptr;
    logic          r_gnt;

    logic          w_any;
    logic          w_pick;
    logic [TW:0]   w_tnext;
    logic          w_tmo;
    logic          w_err;
    logic          w_can_retry;
    lcm_word_t     w_word;

    lcm_rr_pick u_pick (
        .i_req ({iREQ_1, iREQ_0}),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_gnt (w_pick)
    );

    assign w_word  = w_pick ? iDATA_1 : iDATA_0;
    assign w_tnext = {1'b0, r_tcnt} + {{TW{1'b0}}, 1'b1};
    assign w_tmo   = (w_tnext >= {1'b0, TMAX});
    assign w_err   = !(iRDY && iACK);

`ifdef LCM_ARB_RETRY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

    logic [RW-1:0] r_retry;

    assign w_can_retry = (r_retry < RMAX);
`else
    // No retry hardware: MAX_RETRY only matters in the retry build.
    assign w_can_retry = 1'b0 && (MAX_RETRY != 0);
`endif

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= IDLE;
            r_tcnt  <= '0;
            r_ptr   <= 1'b0;
            r_gnt   <= 1'b0;
            oDATA   <= '0;
            oSTR    <= 1'b0;
            oBUSY   <= 1'b0;
            oDONE_0 <= 1'b0;
            oDONE_1 <= 1'b0;
            oERR_0  <= 1'b0;
            oERR_1  <= 1'b0;
`ifdef LCM_ARB_RETRY_EN
            r_retry <= '0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_pick;
                        oDATA   <= w_word;
                        oBUSY   <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    oSTR    <= 1'b1;
                    r_tcnt  <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (iRDY || w_tmo) begin
                        oSTR <= 1'b0;
                        if (iRDY && !iACK && w_can_retry) begin
`ifdef LCM_ARB_RETRY_EN
                            r_retry <= r_retry + RW'(1);
`endif
                            r_state <= GAP;
                        end else begin
                            oDONE_0 <= !r_gnt;
                            oDONE_1 <= r_gnt;
                            oERR_0  <= !r_gnt && w_err;
                            oERR_1  <= r_gnt && w_err;
                            r_state <= DONE;
                        end
                    end else begin
                        r_tcnt <= w_tnext[TW-1:0];
                    end
                end
                GAP: begin
                    // Re-raise on leaving GAP so the strobe gap is one cycle.
                    oSTR    <= 1'b1;
                    r_state <= ISSUE;
                end
                DONE: begin
                    oDONE_0 <= 1'b0;
                    oDONE_1 <= 1'b0;
                    oERR_0  <= 1'b0;
                    oERR_1  <= 1'b0;
                    oBUSY   <= 1'b0;
                    r_ptr   <= !r_gnt;
`ifdef LCM_ARB_RETRY_EN
                    r_retry <= '0;
`endif
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcm_reg_arbiter.sv
// Bench for lcm_reg_arbiter: timeline model per transaction, per-cycle
// compare, scripted serial-controller responder.
module tb_lcm_reg_arbiter;

    localparam int TMO  = 15;
    localparam int MAXR = 3;
    localparam int N    = 2048;
`ifdef LCM_ARB_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iREQ_0 = 1'b0;
    logic        iREQ_1 = 1'b0;
    logic [15:0] iDATA_0 = '0;
    logic [15:0] iDATA_1 = '0;
    logic        iRDY = 1'b0;
    logic        iACK = 1'b0;
    logic        oDONE_0, oDONE_1, oERR_0, oERR_1;
    logic        oBUSY, oSTR;
    logic [15:0] oDATA;

    lcm_reg_arbiter #(
        .MAX_RETRY (MAXR),
        .TIMEOUT   (TMO)
    ) dut (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .iREQ_0  (iREQ_0),
        .iREQ_1  (iREQ_1),
        .iDATA_0 (iDATA_0),
        .iDATA_1 (iDATA_1),
        .oDONE_0 (oDONE_0),
        .oDONE_1 (oDONE_1),
        .oERR_0  (oERR_0),
        .oERR_1  (oERR_1),
        .oBUSY   (oBUSY),
        .oDATA   (oDATA),
        .oSTR    (oSTR),
        .iRDY    (iRDY),
        .iACK    (iACK)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    // Expected output timeline, indexed by cycle number.
    bit        ex_str [N];
    bit        ex_busy[N];
    bit        ex_done[2][N];
    bit        ex_err [2][N];
    bit [15:0] ex_data[N];

    int  vecs = 0;
    int  errs = 0;
    bit  chk_en = 1'b0;
    bit  prio = 1'b0;

    // Responder script: per issue, strobe-high cycles before iRDY (d+1th
    // high cycle carries iRDY), -1 = never answer; ack flag.
    int scr_n;
    int scr_d[8];
    int scr_a[8];
    int dq[$];
    int aq[$];
    int hi = 0;
    int cur_d = -1;
    int cur_a = 0;
    int rises = 0;
    int last_len = 0;

    function automatic logic [15:0] dat(input int g);
        return (g == 0) ? 16'h0C3A : 16'h2C07;
    endfunction

    function automatic int plan(input int g, input logic [15:0] d,
                                input int n0);
        int s, e, h;
        bit err;
        for (int c = n0 + 1; c < N; c++) ex_data[c] = d;
        s = n0 + 2;
        e = n0 + 1;
        err = 1'b1;
        for (int i = 0; i < scr_n; i++) begin
            h = (scr_d[i] < 0) ? TMO : scr_d[i] + 1;
            for (int c = s; c < s + h; c++) ex_str[c] = 1'b1;
            e = s + h - 1;
            if (scr_d[i] < 0) begin err = 1'b1; break; end
            if (scr_a[i] != 0) begin err = 1'b0; break; end
            if (!RETRY || i >= MAXR) begin err = 1'b1; break; end
            s = e + 2;
        end
        for (int c = n0 + 1; c <= e + 1; c++) ex_busy[c] = 1'b1;
        ex_done[g][e+1] = 1'b1;
        ex_err[g][e+1]  = err;
        return e + 1;
    endfunction

    function automatic void wipe(input int from);
        for (int c = from; c < N; c++) begin
            ex_str[c] = 0; ex_busy[c] = 0; ex_data[c] = '0;
            ex_done[0][c] = 0; ex_done[1][c] = 0;
            ex_err[0][c] = 0; ex_err[1][c] = 0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        logic [21:0] got, exp;
        int c;
        @(negedge iCLK);
        c = cyc;
        if (chk_en && c < N) begin
            got = {oSTR, oBUSY, oDONE_0, oERR_0, oDONE_1, oERR_1, oDATA};
            exp = {ex_str[c], ex_busy[c], ex_done[0][c], ex_err[0][c],
                   ex_done[1][c], ex_err[1][c], ex_data[c]};
            check($sformatf("cycle%0d", c), 32'(got), 32'(exp));
        end
        if (!iRST_N) begin
            hi = 0; iRDY = 0; iACK = 0;
        end else if (oSTR) begin
            if (hi == 0) begin
                rises++;
                if (dq.size() > 0) begin
                    cur_d = dq.pop_front(); cur_a = aq.pop_front();
                end else begin
                    cur_d = -1; cur_a = 0;
                end
            end
            hi++;
            iRDY = (cur_d >= 0 && hi == cur_d + 1);
            iACK = iRDY && (cur_a != 0);
        end else begin
            if (hi != 0) last_len = hi;
            hi = 0; iRDY = 0; iACK = 0;
        end
    endtask

    task automatic push_script();
        for (int i = 0; i < scr_n; i++) begin
            dq.push_back(scr_d[i]); aq.push_back(scr_a[i]);
        end
    endtask

    task automatic set_req(input int g, input bit v, input logic [15:0] d);
        if (g == 0) begin
            iREQ_0 = v; if (v) iDATA_0 = d;
        end else begin
            iREQ_1 = v; if (v) iDATA_1 = d;
        end
    endtask

    task automatic run_one(input int g, input logic [15:0] d, input bit xerr,
                           input int xiss, input int xlen, input string tag);
        int n0, dn, r0;
        logic gd, ge;
        r0 = rises;
        push_script();
        set_req(g, 1'b1, d);
        n0 = cyc;
        dn = plan(g, d, n0);
        prio = (g == 0);
        while (cyc < dn) tick();
        gd = (g == 0) ? oDONE_0 : oDONE_1;
        ge = (g == 0) ? oERR_0 : oERR_1;
        set_req(g, 1'b0, d);
        tick();
        check({tag, "_done"}, 32'(gd), 32'd1);
        check({tag, "_err"}, 32'(ge), 32'(xerr));
        check({tag, "_issues"}, rises - r0, xiss);
        check({tag, "_strlen"}, last_len, xlen);
        dq.delete(); aq.delete();
    endtask

    task automatic run_two(input int dly, input int xfirst, input string tag);
        int k, dw, dl, w, l, first;
        w = (dly == 0) ? int'(prio) : 0;
        l = 1 - w;
        scr_n = 1; scr_d[0] = 3; scr_a[0] = 1;
        push_script(); push_script();
        set_req(0, 1'b1, dat(0));
        if (dly == 0) set_req(1, 1'b1, dat(1));
        k = cyc;
        dw = plan(w, dat(w), k);
        dl = plan(l, dat(l), dw + 1);
        prio = (l == 0);
        first = -1;
        while (cyc < dl) begin
            tick();
            if (first < 0 && (oDONE_0 || oDONE_1)) first = int'(oDONE_1);
            if (dly > 0 && cyc == k + dly) set_req(1, 1'b1, dat(1));
            if (cyc == dw) set_req(w, 1'b0, dat(w));
            if (cyc == dl) set_req(l, 1'b0, dat(l));
        end
        tick();
        check({tag, "_first"}, first, xfirst);
        dq.delete(); aq.delete();
    endtask

    initial begin
        int n0;
        @(negedge iCLK);
        check("reset_outs",
              32'({oSTR, oBUSY, oDONE_0, oERR_0, oDONE_1, oERR_1, oDATA}), 0);
        chk_en = 1'b1;
        tick();
        iRST_N = 1'b1;
        tick(); tick();

        run_two(0, 0, "rr_init");

        scr_n = 1; scr_d[0] = 10; scr_a[0] = 1;
        run_one(0, 16'h0802, 1'b0, 1, 11, "single");
        check("single_data", 32'(oDATA), 32'h0802);
        tick();

        run_two(0, 1, "rr_second");
        run_two(4, 0, "late_req");

        scr_n = 3;
        scr_d[0] = 2; scr_a[0] = 0;
        scr_d[1] = 3; scr_a[1] = 0;
        scr_d[2] = 1; scr_a[2] = 1;
        run_one(0, 16'h1C81, RETRY ? 1'b0 : 1'b1, RETRY ? 3 : 1,
                RETRY ? 2 : 3, "nack");
        tick();

        scr_n = 4;
        for (int i = 0; i < 4; i++) begin scr_d[i] = 2; scr_a[i] = 0; end
        run_one(1, 16'h3C44, 1'b1, RETRY ? 4 : 1, 3, "exhaust");
        tick();

        scr_n = 1; scr_d[0] = -1; scr_a[0] = 0;
        run_one(0, 16'h0C10, 1'b1, 1, 15, "timeout");
        tick();

        scr_n = 1; scr_d[0] = -1; scr_a[0] = 0;
        push_script();
        set_req(1, 1'b1, 16'h2855);
        n0 = cyc;
        void'(plan(1, 16'h2855, n0));
        while (cyc < n0 + 6) tick();
        @(posedge iCLK);
        #2;
        iRST_N = 1'b0;
        wipe(cyc);
        prio = 1'b0;
        set_req(1, 1'b0, 16'h2855);
        dq.delete(); aq.delete();
        #1;
        check("rst_mid_outs",
              32'({oSTR, oBUSY, oDONE_0, oERR_0, oDONE_1, oERR_1, oDATA}), 0);
        tick(); tick();
        #2;
        iRST_N = 1'b1;
        tick();
        run_two(0, 0, "rr_restart");
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
